// File: rtl/rr_gate_arbiter_pkg.sv
// rr_gate_arbiter_pkg
//   Shared types and helpers for the round-robin gate arbiter.
//   - arb_state_e : controller states (IDLE, GRANT, GAP)
//   - ENC_*       : state encodings backing the enum
//   - idx_to_onehot / onehot_to_idx : conversions sized for the largest
//     supported requester count (16)
package rr_gate_arbiter_pkg;

  localparam int unsigned MAX_N   = 16;
  localparam int unsigned MAX_IDW = 4;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_GRANT = 2'd1;
  localparam logic [1:0] ENC_GAP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ENC_IDLE,
    GRANT = ENC_GRANT,
    GAP   = ENC_GAP
  } arb_state_e;

  function automatic logic [MAX_N-1:0] idx_to_onehot(input logic [MAX_IDW-1:0] idx);
    logic [MAX_N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [MAX_IDW-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [MAX_IDW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | MAX_IDW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_gate_arbiter_pick.sv
// rr_pick
//   Combinational rotate-priority picker. Scans req starting at ptr,
//   wrapping from N-1 back to 0, and reports the first set bit.
//   Ports:
//     req     in  N    request vector
//     ptr     in  IDW  index scanned first (0..N-1)
//     winner  out IDW  index of first set request at or after ptr
//     any_req out 1    at least one request is set
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] winner,
  output logic           any_req
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!any_req && req[IDW'(idx)]) begin
        any_req = 1'b1;
        winner  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_gate_arbiter.sv
// rr_gate_arbiter
//   Round-robin arbiter sharing one gate-level resource among N requesters.
//   One owner at a time; the grant is held until the owner drops REQ or
//   pulses DONE, followed by a one-cycle GAP before arbitration resumes.
//   Optional feature macro: ARB_TIMEOUT_EN (forced release after HOLD_MAX
//   GRANT cycles, signalled by a TMO pulse).
//   Ports:
//     CK      in   1    clock, rising edge
//     CDN     in   1    asynchronous active-low reset
//     REQ     in   N    level requests, held until granted
//     DONE    in   N    one-cycle release pulse from the owner
//     GNT     out  N    registered one-hot grant
//     GNT_ID  out  IDW  binary index of owner (valid while BUSY=1)
//     BUSY    out  1    a grant is active
//     TMO     out  1    one-cycle pulse on forced release
module rr_gate_arbiter
  import rr_gate_arbiter_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned IDW      = $clog2(N),
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic           CK,
  input  logic           CDN,
  input  logic [N-1:0]   REQ,
  input  logic [N-1:0]   DONE,
  output logic [N-1:0]   GNT,
  output logic [IDW-1:0] GNT_ID,
  output logic           BUSY,
  output logic           TMO
);

  if (N < 2 || N > MAX_N || HOLD_MAX < 1) begin : g_param_check
    $error("rr_gate_arbiter: N must be 2..16 and HOLD_MAX at least 1");
  end

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           busy_q, busy_d;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] ptr_after_owner;
  logic           any_req;
  logic           release_c;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic          hold_expired;
`endif

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req     (REQ),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    release_c       = !REQ[owner_q] || DONE[owner_q];
    ptr_after_owner = (owner_q == IDW'(N - 1)) ? '0 : owner_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
    // The entry edge already counts as GRANT cycle one, so the HOLD_MAX-th
    // cycle is seen while the counter still reads HOLD_MAX-1.
    hold_expired    = (cnt_q == CW'(HOLD_MAX - 1));
`endif
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          owner_d = winner;
          gnt_d   = N'(idx_to_onehot(MAX_IDW'(winner)));
          busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (release_c) begin
          state_d = GAP;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_after_owner;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_expired) begin
          state_d = GAP;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_after_owner;
          tmo_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign GNT    = gnt_q;
  assign GNT_ID = owner_q;
  assign BUSY   = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign TMO    = tmo_q;
`else
  assign TMO    = 1'b0;
`endif

endmodule

// File: tb/tb_rr_gate_arbiter.sv
// tb_rr_gate_arbiter
//   Self-checking bench for rr_gate_arbiter (N=4, HOLD_MAX=16). Expected
//   outputs are queued when inputs are driven and compared one cycle later.
module tb_rr_gate_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned IDW      = 2;
  localparam int unsigned HOLD_MAX = 16;

  logic           CK;
  logic           CDN;
  logic [N-1:0]   REQ;
  logic [N-1:0]   DONE;
  logic [N-1:0]   GNT;
  logic [IDW-1:0] GNT_ID;
  logic           BUSY;
  logic           TMO;

  rr_gate_arbiter #(.N(N), .IDW(IDW), .HOLD_MAX(HOLD_MAX)) dut (
    .CK     (CK),
    .CDN    (CDN),
    .REQ    (REQ),
    .DONE   (DONE),
    .GNT    (GNT),
    .GNT_ID (GNT_ID),
    .BUSY   (BUSY),
    .TMO    (TMO)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       tmo;
    logic       id_care;
  } exp_t;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] done;
    exp_t       exp;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] id,
                              input logic busy, input logic tmo, input logic care);
    exp_t e;
    e.gnt     = g;
    e.id      = id;
    e.busy    = busy;
    e.tmo     = tmo;
    e.id_care = care;
    return e;
  endfunction

  task automatic add_vec(input logic [3:0] r, input logic [3:0] d, input exp_t e);
    vec_t v;
    v.req  = r;
    v.done = d;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic compare_pop(input string name);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got GNT=%b", name, GNT);
      return;
    end
    e = sb.pop_front();
    if (GNT !== e.gnt || BUSY !== e.busy || TMO !== e.tmo ||
        (e.id_care && GNT_ID !== e.id)) begin
      $display("FAIL %s: got GNT=%b GNT_ID=%0d BUSY=%b TMO=%b, expected GNT=%b GNT_ID=%0d BUSY=%b TMO=%b",
               name, GNT, GNT_ID, BUSY, TMO, e.gnt, e.id, e.busy, e.tmo);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step(input string name, input logic [3:0] r, input logic [3:0] d,
                      input exp_t e);
    REQ  = r;
    DONE = d;
    sb.push_back(e);
    @(posedge CK);
    #1;
    compare_pop(name);
  endtask

  task automatic expect_now(input string name, input exp_t e);
    sb.push_back(e);
    compare_pop(name);
  endtask

  initial begin
    logic [3:0] oh;
    logic [1:0] id;
    exp_t       z;

    z = mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Fairness: all requesting, owner pulses DONE on its third cycle,
    // non-owners pulse DONE meanwhile and must be ignored.
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      id = 2'(k % 4);
      add_vec(4'b1111, 4'b0000, mk(oh, id, 1'b1, 1'b0, 1'b1));
      add_vec(4'b1111, ~oh,     mk(oh, id, 1'b1, 1'b0, 1'b1));
      add_vec(4'b1111, oh,      z);
      add_vec((k == 4) ? 4'b0000 : 4'b1111, 4'b0000, z);
    end
    // Single requester; a non-owner request raised and dropped during the
    // grant must never be granted.
    add_vec(4'b0100, 4'b0000, mk(4'b0100, 2'd2, 1'b1, 1'b0, 1'b1));
    add_vec(4'b0110, 4'b0000, mk(4'b0100, 2'd2, 1'b1, 1'b0, 1'b1));
    add_vec(4'b0000, 4'b0000, z);
    add_vec(4'b0000, 4'b0000, z);
    add_vec(4'b0000, 4'b0000, z);
    // Wrap and skip around the pointer.
    add_vec(4'b1000, 4'b0000, mk(4'b1000, 2'd3, 1'b1, 1'b0, 1'b1));
    add_vec(4'b1001, 4'b1000, z);
    add_vec(4'b1001, 4'b0000, z);
    add_vec(4'b1001, 4'b0000, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1));
    add_vec(4'b1000, 4'b0001, z);
    add_vec(4'b1000, 4'b0000, z);
    add_vec(4'b1000, 4'b0000, mk(4'b1000, 2'd3, 1'b1, 1'b0, 1'b1));
    add_vec(4'b0000, 4'b0000, z);
    add_vec(4'b0000, 4'b0000, z);

    // Reset with all requests active.
    CDN  = 1'b1;
    REQ  = 4'b0000;
    DONE = 4'b0000;
    #3;
    CDN = 1'b0;
    REQ = 4'b1111;
    #1;
    expect_now("rst_async", mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++)
      step("rst_hold", 4'b1111, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b1));
    REQ = 4'b0000;
    CDN = 1'b1;
    step("rst_release", 4'b0000, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b1));

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].req, vecs[i].done, vecs[i].exp);

`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++)
      step("tmo_hold", 4'b0011, 4'b0000, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1));
    step("tmo_pulse", 4'b0011, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b1, 1'b0));
    step("tmo_idle",  4'b0011, 4'b0000, z);
    step("tmo_next",  4'b0011, 4'b0000, mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b1));
    step("tmo_rel",   4'b0000, 4'b0000, z);
    step("tmo_end",   4'b0000, 4'b0000, z);
`else
    for (int i = 0; i < 100; i++)
      step("hold_long", 4'b0011, 4'b0000, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1));
    step("hold_rel", 4'b0000, 4'b0000, z);
    step("hold_end", 4'b0000, 4'b0000, z);
`endif

    // Reset asserted in the middle of a grant.
    step("mid_grant", 4'b0010, 4'b0000, mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b1));
    step("mid_hold",  4'b0010, 4'b0000, mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b1));
    #2;
    CDN = 1'b0;
    #1;
    expect_now("mid_rst_async", mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b1));
    step("mid_rst_hold", 4'b0011, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b1));
    step("mid_rst_hold", 4'b0011, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b1));
    CDN = 1'b1;
    step("mid_restart", 4'b0011, 4'b0000, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1));
    step("mid_rel",     4'b0000, 4'b0000, z);
    step("mid_end",     4'b0000, 4'b0000, z);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
